// File: rtl/sqrt_arb_pkg.sv
// Shared widths, defaults and FSM state encoding for the sqrt arbiter slice.
// Pure declarations: no logic, no latency, no flow control.
package sqrt_arb_pkg;

  localparam int OP_W        = 16;
  localparam int RES_W       = 8;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 64;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_ISSUE = 2'd1;
  localparam arb_state_t ST_WAIT  = 2'd2;
  localparam arb_state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester after last_grant, wrapping; one-hot plus index.
// Purely combinational (zero latency); no backpressure of its own.
module rr_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int N   = DEF_NUM_REQ,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!any && req[(int'(last_grant) + i) % N]) begin
        any                                = 1'b1;
        grant[(int'(last_grant) + i) % N]  = 1'b1;
        grant_idx                          = IDW'((int'(last_grant) + i) % N);
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one external sqrt core among NUM_REQ requesters, one transaction at a time.
// req_ready in IDLE, sq_start next cycle, rsp_valid one cycle after sq_done; rsp held until rsp_ready.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  parameter int  TIMEOUT = DEF_TIMEOUT,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*OP_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [RES_W-1:0]        rsp_data,
  output logic                    rsp_err,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic                    sq_start,
  output logic [OP_W-1:0]         sq_data,
  input  logic [RES_W-1:0]        sq_result,
  input  logic                    sq_done,
  output logic                    busy,
  output logic [IDW-1:0]          grant_id
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t         state;
  logic [IDW-1:0]     last_grant;
  logic [OP_W-1:0]    operand;
  logic [RES_W-1:0]   result;
  logic               result_err;
  logic [CNT_W-1:0]   wait_cnt;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDW-1:0]     win_idx;
  logic               win_any;
  logic               rsp_take;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (win_onehot),
    .grant_idx  (win_idx),
    .any        (win_any)
  );

  assign req_ready = (state == ST_IDLE) ? win_onehot : '0;
  assign sq_start  = (state == ST_ISSUE);
  assign sq_data   = (state == ST_ISSUE || state == ST_WAIT) ? operand : '0;
  assign busy      = (state != ST_IDLE);
  assign rsp_data  = (state == ST_RESP) ? result : '0;
  assign rsp_err   = (state == ST_RESP) && result_err;
  // Only the granted requester's rsp_ready can close the response.
  assign rsp_take  = (state == ST_RESP) && rsp_ready[grant_id];

  always_comb begin
    rsp_valid = '0;
    if (state == ST_RESP) begin
      rsp_valid[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      grant_id   <= '0;
      operand    <= '0;
      result     <= '0;
      result_err <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            operand  <= req_data[win_idx*OP_W +: OP_W];
            grant_id <= win_idx;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= CNT_W'(1);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion on the final WAIT cycle still beats the timeout.
          if (sq_done) begin
            result     <= sq_result;
            result_err <= 1'b0;
            wait_cnt   <= '0;
            state      <= ST_RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
            result     <= '0;
            result_err <= 1'b1;
            wait_cnt   <= '0;
            state      <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_take) begin
            last_grant <= grant_id;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one sqrt core.
REQ-002 Parameter TIMEOUT, default 64, max WAIT cycles before the transaction is aborted with error.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  NUM_REQ  per-requester operand valid.
REQ-006 req_data  in  NUM_REQ*16  packed operands; requester i at bits [16i+15:16i].
REQ-007 req_ready  out  NUM_REQ  one-hot acceptance pulse.
REQ-008 rsp_valid  out  NUM_REQ  one-hot result valid for the granted requester.
REQ-009 rsp_data  out  8  shared result bus, floor(sqrt(operand)).
REQ-010 rsp_err  out  1  result is a timeout abort; qualified by any rsp_valid.
REQ-011 rsp_ready  in  NUM_REQ  per-requester result acceptance.
REQ-012 sq_start  out  1  start pulse to the sqrt core.
REQ-013 sq_data  out  16  operand to the sqrt core.
REQ-014 sq_result  in  8  sqrt core result, valid when sq_done=1.
REQ-015 sq_done  in  1  sqrt core completion, sampled only in WAIT.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 grant_id  out  clog2(NUM_REQ)  index of current/last granted requester.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-019 IDLE: if any req_valid, pick winner round-robin starting at (last_grant+1) mod NUM_REQ, pulse req_ready[winner] one cycle, register operand and grant_id, go ISSUE.
REQ-020 IDLE with no req_valid: stay; all outputs except grant_id low.
REQ-021 ISSUE: sq_start=1 for exactly one cycle, sq_data=registered operand, go WAIT; sq_data holds operand through WAIT.
REQ-022 WAIT: count cycles from 1; on sq_done=1 register sq_result, rsp_err=0, go RESP.
REQ-023 WAIT: if count reaches TIMEOUT with no sq_done, register result 0, rsp_err=1, go RESP.
REQ-024 sq_done and timeout in the same cycle: sq_done wins, rsp_err=0.
REQ-025 RESP: rsp_valid[grant_id]=1, rsp_data/rsp_err stable until rsp_ready[grant_id]=1; then go IDLE, last_grant=grant_id.
REQ-026 rsp_ready of non-granted requesters ignored; rsp_ready high on first RESP cycle completes in that cycle.
REQ-027 sq_done outside WAIT ignored (no state change, no capture).
REQ-028 req_valid must be held by a requester until its req_ready; no request is lost or duplicated.
REQ-029 Latency: req_ready at cycle 0, sq_start at cycle 1, rsp_valid one cycle after sq_done; minimum 4-cycle turnaround per transaction.
REQ-030 Round-robin guarantees each continuously valid requester a grant within NUM_REQ transactions.

Reset
REQ-031 On rst: state IDLE, last_grant=NUM_REQ-1 (requester 0 first), grant_id=0, all handshake outputs 0, sq_start=0, sq_data=0, rsp_data=0, rsp_err=0, busy=0, WAIT counter 0.
REQ-032 Reset mid-transaction drops it silently; a late sq_done after reset is ignored.

Structure
REQ-033 Shared package sqrt_arb_pkg holds the state enum, operand width 16, result width 8, default NUM_REQ and TIMEOUT.
REQ-034 Round-robin selection is a sub-module rr_arbiter (req vector, last_grant in; one-hot grant and index out), purely combinational.
REQ-035 The sqrt core is not instantiated inside; it connects via the sq_* ports.

Verification
REQ-036 Single req[0]=64, core model done after 10 cycles with 8 -> one sq_start pulse with sq_data=64, rsp_valid[0], rsp_data=8, rsp_err=0.
REQ-037 After reset all four valid with 0,4096,5000,65535 -> grants in order 0,1,2,3; results 0,64,70,255.
REQ-038 req[0] and req[2] continuously valid -> grants alternate 0,2,0,2; requesters 1,3 never see req_ready.
REQ-039 req[1]=1000, rsp_ready[1] low 5 cycles -> rsp_valid[1] held, rsp_data stable at 31, no new sq_start, new grant only after acceptance.
REQ-040 Core never asserts done, TIMEOUT=64 -> rsp_valid after 64 WAIT cycles with rsp_err=1, rsp_data=0; next request proceeds normally.
REQ-041 rst asserted in WAIT, then sq_done pulses -> all outputs at reset values, done ignored, next simultaneous req[0..3] granted to 0.
